wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
- Two-master to one-slave arbiter for the pipelined Wishbone bus.
- Shares the core's single memory port between the instruction prefetch unit (master 0) and the load/store unit (master 1).
- Grants whole bus cycles (cyc windows), tracks outstanding requests and routes each ack/rdata back to the granted master.
- Drains orphaned acks when a master abandons a cycle.

Parameters:
- MAX_OUTSTANDING_POT, 3, log2 of the maximum number of in-flight requests on the slave side (8).
- ROUND_ROBIN, 1'b1, 1 = alternate priority after each granted cycle; 0 = fixed priority, data master wins.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- ifetch_if  wishbone_if.SLAVE  bundle  master 0 (prefetch): cyc, stb, addr[29:0], we, sel[3:0], wdata[31:0] in; stall, ack, rdata[31:0] out.
- data_if  wishbone_if.SLAVE  bundle  master 1 (LSU), same signals.
- mem_if  wishbone_if.MASTER  bundle  to the shared memory/interconnect slave.
- busy_o  out  1  state != IDLE.
- owner_o  out  1  0 = ifetch, 1 = data; valid only when busy_o.
- spurious_ack_o  out  1  one-cycle pulse when mem ack arrives with outstanding count 0.

Behaviour:
- Reset: async on rst_i high. Reset values: state=IDLE, outstanding=0, last_grant=1 (so ifetch wins the first tie in RR mode), busy_o=0, owner_o=0, spurious_ack_o=0.
- IDLE:
  - mem cyc/stb=0.
  - Both masters see stall=1, ack=0.
- Arbitration is registered: a master's cyc seen in IDLE produces a grant next cycle, so first stb reaches mem_if one cycle after cyc rises.
- States: IDLE, GRANT_I, GRANT_D, DRAIN.
- GRANT_x:
  - mem addr/we/sel/wdata/cyc/stb driven from the owner.
  - Owner's stall = mem stall OR (outstanding == 2^POT).
  - When outstanding == 2^POT, mem stb is forced to 0.
  - Owner's ack = mem ack; owner's rdata = mem rdata.
  - Non-owner: stall=1, ack=0, rdata=0.
- Outstanding counter, width POT+1:
  - +1 on accepted request (mem cyc & stb & !stall).
  - -1 on mem ack.
  - Both in the same cycle: unchanged.
  - Ack with count 0: counter stays 0, spurious_ack_o pulses, ack not forwarded.
- Leaving GRANT_x when owner cyc falls:
  - count == 0, other master cyc=1: go to the other GRANT directly (no IDLE bubble).
  - count == 0, other master cyc=0: go to IDLE.
  - count != 0 (aborted cycle): go to DRAIN.
- DRAIN:
  - mem cyc=1, stb=0.
  - Acks decrement the counter and are not forwarded to either master.
  - Both masters see stall=1, ack=0.
  - At count reaching 0 (ack while count==1): go to IDLE.
- Owner cyc re-rising while in DRAIN does not regain the grant until IDLE has been passed through (re-arbitration).
- Priority on a tie (both cyc=1 when a grant decision is made):
  - ROUND_ROBIN=1: the master not in last_grant wins.
  - ROUND_ROBIN=0: data wins.
  - last_grant updates on every GRANT entry.
- Owner cyc=0 with stb=1 is illegal; stb is qualified by cyc.
- owner_o/busy_o are registered from the state.
- Reset mid-transaction: immediate return to IDLE, counter cleared, mem cyc drops; in-flight acks after reset are reported as spurious and dropped.

Decomposition:
- Add wb_arb_state_t (enum IDLE, GRANT_I, GRANT_D, DRAIN) and the owner encodings (OWNER_IFETCH=0, OWNER_DATA=1) to the shared riscv_pkg.
- One natural sub-module: wb_req_counter (up/down saturating counter with full/zero flags, parameter MAX_OUTSTANDING_POT), reusable in the prefetch unit.
- Muxing and the FSM stay in wb_arbiter2.

Test Plan:
- Single fetch burst: ifetch cyc=1, 4 stb addr 0x2000_0000..0x2000_0003, slave acks after 2 cycles → grant 1 cycle after cyc; 4 acks/rdata on ifetch_if; count returns to 0; data_if sees stall=1 throughout; state back to IDLE.
- Tie, ROUND_ROBIN=1, both cyc=1 from reset, each does 1 request → order ifetch, data, ifetch, data; direct GRANT_I↔GRANT_D hand-off with no IDLE cycle. Same stimulus with ROUND_ROBIN=0 → data granted first and again whenever it requests at a decision point.
- Saturation: slave withholds acks, ifetch issues 9 stb → 8 accepted; 9th sees stall=1 and mem stb=0; after one ack the 9th is accepted.
- Abort: ifetch has 3 outstanding then drops cyc, data requests → DRAIN with mem cyc=1, stb=0; 3 acks not forwarded to either master; IDLE, then GRANT_D.
- Simultaneous accept+ack at count 5 → count stays 5. Injected ack in IDLE → spurious_ack_o=1 for exactly 1 cycle, no master ack.
- rst_i asserted asynchronously mid-GRANT_D with 2 outstanding → mem cyc=0 immediately; busy_o=0; the 2 late acks after release each pulse spurious_ack_o.

Source files
------------

// File: rtl/wb_arbiter2_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Holds the state/owner encodings and the tie-break rule used at each grant decision.
package wb_arbiter2_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_I = 2'd1;
    localparam logic [1:0] ST_GRANT_D = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        GRANT_I = ST_GRANT_I,
        GRANT_D = ST_GRANT_D,
        DRAIN   = ST_DRAIN
    } wb_arb_state_t;

    localparam logic OWNER_IFETCH = 1'b0;
    localparam logic OWNER_DATA   = 1'b1;

    // Winner of a grant decision; on a tie RR picks the master that did not win last.
    function automatic logic arb_pick(input logic req_i, input logic req_d,
                                      input logic last_grant, input logic round_robin);
        if (req_i && req_d) begin
            return round_robin ? ~last_grant : OWNER_DATA;
        end
        return req_d ? OWNER_DATA : OWNER_IFETCH;
    endfunction

endpackage

// File: rtl/wb_arbiter2_if.sv
// Pipelined Wishbone bundle; MASTER drives the request side, SLAVE returns stall/ack/rdata.
interface wishbone_if;
    logic        cyc;
    logic        stb;
    logic [29:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;

    modport MASTER (output cyc, stb, addr, we, sel, wdata, input stall, ack, rdata);
    modport SLAVE  (input cyc, stb, addr, we, sel, wdata, output stall, ack, rdata);
endinterface

// File: rtl/wb_arbiter2_req_counter.sv
// Up/down in-flight request counter saturating at 0 and 2^POT; flags update one cycle after inc/dec.
// No backpressure of its own: the caller uses full_o to stall new requests.
module wb_req_counter #(
    parameter int unsigned MAX_OUTSTANDING_POT = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         inc_i,
    input  logic                         dec_i,
    output logic [MAX_OUTSTANDING_POT:0] count_o,
    output logic                         full_o,
    output logic                         zero_o
);
    localparam int unsigned W = MAX_OUTSTANDING_POT + 1;
    localparam logic [W-1:0] MAX = W'(1) << MAX_OUTSTANDING_POT;

    logic [W-1:0] count_q, count_d;
    logic         inc_ok, dec_ok;

    assign full_o  = (count_q == MAX);
    assign zero_o  = (count_q == '0);
    assign count_o = count_q;

    // A decrement at zero is a stray ack and is ignored rather than wrapping.
    assign inc_ok = inc_i && !full_o;
    assign dec_ok = dec_i && !zero_o;

    always_comb begin
        count_d = count_q;
        if (inc_ok && !dec_ok) begin
            count_d = count_q + W'(1);
        end else if (dec_ok && !inc_ok) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave pipelined Wishbone arbiter; grant registered, first stb one cycle after cyc.
// Non-owners and DRAIN see stall=1; owner stalls on mem stall or when 2^POT requests are in flight.
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING_POT = 3,
    parameter bit          ROUND_ROBIN         = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    wishbone_if.SLAVE  ifetch_if,
    wishbone_if.SLAVE  data_if,
    wishbone_if.MASTER mem_if,
    output logic       busy_o,
    output logic       owner_o,
    output logic       spurious_ack_o
);
    localparam int unsigned W = MAX_OUTSTANDING_POT + 1;

    logic [1:0]   state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         owner_q, owner_d;
    logic         busy_q;
    logic         spurious_q;
    logic         win;

    logic [W-1:0] count;
    logic         full, zero;
    logic         granted, own_data, own_cyc, own_stb, oth_cyc;
    logic         accept, ack_fwd, ack_spur;

    assign granted  = (state_q == ST_GRANT_I) || (state_q == ST_GRANT_D);
    assign own_data = (state_q == ST_GRANT_D);
    assign own_cyc  = own_data ? data_if.cyc : ifetch_if.cyc;
    assign own_stb  = own_data ? data_if.stb : ifetch_if.stb;
    assign oth_cyc  = own_data ? ifetch_if.cyc : data_if.cyc;

    assign accept   = mem_if.cyc && mem_if.stb && !mem_if.stall;
    assign ack_spur = mem_if.ack && zero;
    assign ack_fwd  = mem_if.ack && !zero && granted;

    wb_req_counter #(
        .MAX_OUTSTANDING_POT(MAX_OUTSTANDING_POT)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (accept),
        .dec_i  (mem_if.ack),
        .count_o(count),
        .full_o (full),
        .zero_o (zero)
    );

    always_comb begin
        mem_if.cyc   = 1'b0;
        mem_if.stb   = 1'b0;
        mem_if.addr  = '0;
        mem_if.we    = 1'b0;
        mem_if.sel   = '0;
        mem_if.wdata = '0;
        if (granted) begin
            mem_if.cyc   = own_cyc;
            mem_if.stb   = own_cyc && own_stb && !full;
            mem_if.addr  = own_data ? data_if.addr  : ifetch_if.addr;
            mem_if.we    = own_data ? data_if.we    : ifetch_if.we;
            mem_if.sel   = own_data ? data_if.sel   : ifetch_if.sel;
            mem_if.wdata = own_data ? data_if.wdata : ifetch_if.wdata;
        end else if (state_q == ST_DRAIN) begin
            // Keep the cycle open so the slave can return acks of the abandoned requests.
            mem_if.cyc = 1'b1;
        end
    end

    always_comb begin
        ifetch_if.stall = 1'b1;
        ifetch_if.ack   = 1'b0;
        ifetch_if.rdata = '0;
        data_if.stall   = 1'b1;
        data_if.ack     = 1'b0;
        data_if.rdata   = '0;
        if (state_q == ST_GRANT_I) begin
            ifetch_if.stall = mem_if.stall || full;
            ifetch_if.ack   = ack_fwd;
            ifetch_if.rdata = mem_if.rdata;
        end else if (state_q == ST_GRANT_D) begin
            data_if.stall = mem_if.stall || full;
            data_if.ack   = ack_fwd;
            data_if.rdata = mem_if.rdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        win          = arb_pick(ifetch_if.cyc, data_if.cyc, last_grant_q, ROUND_ROBIN);
        case (state_q)
            ST_IDLE: begin
                if (ifetch_if.cyc || data_if.cyc) begin
                    state_d      = win ? ST_GRANT_D : ST_GRANT_I;
                    last_grant_d = win;
                    owner_d      = win;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (!own_cyc) begin
                    if (!zero) begin
                        state_d = ST_DRAIN;
                    end else if (oth_cyc) begin
                        state_d      = own_data ? ST_GRANT_I : ST_GRANT_D;
                        last_grant_d = !own_data;
                        owner_d      = !own_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (zero || (mem_if.ack && (count == W'(1)))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= OWNER_DATA;
            owner_q      <= OWNER_IFETCH;
            busy_q       <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            busy_q       <= (state_d != ST_IDLE);
            spurious_q   <= ack_spur;
        end
    end

    assign busy_o         = busy_q;
    assign owner_o        = owner_q;
    assign spurious_ack_o = spurious_q;
endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: a round-robin instance carries most scenarios, a fixed-priority one the tie rule.
module tb_wb_arbiter2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, owner, spur;
    logic fx_busy, fx_owner, fx_spur;
    int   passed = 0;
    int   total  = 0;

    wishbone_if ifi ();
    wishbone_if dai ();
    wishbone_if mem ();
    wishbone_if fx_i ();
    wishbone_if fx_d ();
    wishbone_if fx_m ();

    always #5 clk = ~clk;

    wb_arbiter2 #(.MAX_OUTSTANDING_POT(3), .ROUND_ROBIN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .ifetch_if(ifi), .data_if(dai), .mem_if(mem),
        .busy_o(busy), .owner_o(owner), .spurious_ack_o(spur)
    );

    wb_arbiter2 #(.MAX_OUTSTANDING_POT(3), .ROUND_ROBIN(1'b0)) dut_fx (
        .clk_i(clk), .rst_i(rst), .ifetch_if(fx_i), .data_if(fx_d), .mem_if(fx_m),
        .busy_o(fx_busy), .owner_o(fx_owner), .spurious_ack_o(fx_spur)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifi.cyc = 0;  ifi.stb = 0;  ifi.addr = '0;  ifi.we = 0;  ifi.sel = 4'hF;  ifi.wdata = '0;
        dai.cyc = 0;  dai.stb = 0;  dai.addr = '0;  dai.we = 0;  dai.sel = 4'hF;  dai.wdata = '0;
        fx_i.cyc = 0; fx_i.stb = 0; fx_i.addr = '0; fx_i.we = 0; fx_i.sel = 4'hF; fx_i.wdata = '0;
        fx_d.cyc = 0; fx_d.stb = 0; fx_d.addr = '0; fx_d.we = 0; fx_d.sel = 4'hF; fx_d.wdata = '0;
        mem.stall = 0;  mem.ack = 0;  mem.rdata = '0;
        fx_m.stall = 0; fx_m.ack = 0; fx_m.rdata = '0;
    endtask

    task automatic apply_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ifi.cyc = 1; ifi.stb = 1; dai.cyc = 1; dai.stb = 1;
        tick();
        tick();
        total++;
        if ({busy, owner, spur, mem.cyc, mem.stb} !== 5'b00000)
            $display("FAIL reset_outputs: busy/owner/spur/cyc/stb=%b expected 00000", {busy, owner, spur, mem.cyc, mem.stb});
        else passed++;
        total++;
        if ({ifi.stall, dai.stall, ifi.ack, dai.ack, dut.u_cnt.count_o} !== 8'b1100_0000)
            $display("FAIL reset_masters: stall/ack/count=%b expected 11000000", {ifi.stall, dai.stall, ifi.ack, dai.ack, dut.u_cnt.count_o});
        else passed++;
        rst = 0;
        tick();
        total++;
        if ({busy, owner} !== 2'b10)
            $display("FAIL reset_first_tie: busy/owner=%b expected 10", {busy, owner});
        else passed++;
    endtask

    task automatic test_fetch_burst();
        apply_reset();
        ifi.cyc = 1; ifi.stb = 1; ifi.addr = 30'h2000_0000;
        #1;
        total++;
        if ({busy, mem.cyc, ifi.stall} !== 3'b001)
            $display("FAIL fetch_idle: busy/cyc/stall=%b expected 001", {busy, mem.cyc, ifi.stall});
        else passed++;
        tick();
        for (int w = 1; w <= 6; w++) begin
            ifi.stb   = (w <= 4);
            ifi.addr  = 30'h2000_0000 + 30'(w - 1);
            mem.ack   = (w >= 3);
            mem.rdata = 32'hD000_0000 + 32'(w - 3);
            #1;
            total++;
            if ({mem.cyc, mem.stb, ifi.stall, dai.stall, ifi.ack, dai.ack} !== {1'b1, (w <= 4), 1'b0, 1'b1, (w >= 3), 1'b0})
                $display("FAIL fetch_w%0d: cyc/stb/istall/dstall/iack/dack=%b", w,
                         {mem.cyc, mem.stb, ifi.stall, dai.stall, ifi.ack, dai.ack});
            else passed++;
            if (w <= 4) begin
                total++;
                if (mem.addr !== 30'h2000_0000 + 30'(w - 1))
                    $display("FAIL fetch_addr%0d: got %h expected %h", w, mem.addr, 30'h2000_0000 + 30'(w - 1));
                else passed++;
            end
            if (w >= 3) begin
                total++;
                if ({ifi.rdata, dai.rdata} !== {32'hD000_0000 + 32'(w - 3), 32'h0})
                    $display("FAIL fetch_rdata%0d: ifetch %h data %h", w, ifi.rdata, dai.rdata);
                else passed++;
            end
            tick();
        end
        mem.ack = 0;
        #1;
        total++;
        if ({busy, dut.u_cnt.count_o} !== 5'b1_0000)
            $display("FAIL fetch_count: busy/count=%b expected 10000", {busy, dut.u_cnt.count_o});
        else passed++;
        ifi.cyc = 0;
        tick();
        total++;
        if ({busy, mem.cyc} !== 2'b00)
            $display("FAIL fetch_idle_end: busy/cyc=%b expected 00", {busy, mem.cyc});
        else passed++;
    endtask

    task automatic test_round_robin();
        apply_reset();
        ifi.cyc = 1; ifi.stb = 1; dai.cyc = 1; dai.stb = 1;
        tick();
        total++;
        if ({busy, owner, ifi.stall, dai.stall} !== 4'b1001)
            $display("FAIL rr_tie_ifetch: busy/owner/istall/dstall=%b expected 1001", {busy, owner, ifi.stall, dai.stall});
        else passed++;
        tick();
        ifi.stb = 0; mem.ack = 1; mem.rdata = 32'h1111_0000;
        #1;
        total++;
        if ({ifi.ack, dai.ack} !== 2'b10)
            $display("FAIL rr_ack_i: iack/dack=%b expected 10", {ifi.ack, dai.ack});
        else passed++;
        tick();
        mem.ack = 0; ifi.cyc = 0;
        tick();
        ifi.cyc = 1; ifi.stb = 1;
        #1;
        total++;
        if ({busy, owner, dai.stall, ifi.stall} !== 4'b1101)
            $display("FAIL rr_handoff_d: busy/owner/dstall/istall=%b expected 1101", {busy, owner, dai.stall, ifi.stall});
        else passed++;
        tick();
        dai.stb = 0; mem.ack = 1;
        #1;
        total++;
        if ({ifi.ack, dai.ack} !== 2'b01)
            $display("FAIL rr_ack_d: iack/dack=%b expected 01", {ifi.ack, dai.ack});
        else passed++;
        tick();
        mem.ack = 0; dai.cyc = 0;
        tick();
        dai.cyc = 1; dai.stb = 1;
        #1;
        total++;
        if ({busy, owner} !== 2'b10)
            $display("FAIL rr_handoff_i: busy/owner=%b expected 10", {busy, owner});
        else passed++;
        tick();
        ifi.stb = 0; mem.ack = 1;
        tick();
        mem.ack = 0; ifi.cyc = 0;
        tick();
        total++;
        if ({busy, owner} !== 2'b11)
            $display("FAIL rr_handoff_d2: busy/owner=%b expected 11", {busy, owner});
        else passed++;
        tick();
        dai.stb = 0; mem.ack = 1;
        tick();
        mem.ack = 0; dai.cyc = 0;
        tick();
        total++;
        if (busy !== 1'b0)
            $display("FAIL rr_idle: busy=%b expected 0", busy);
        else passed++;
        ifi.cyc = 1; dai.cyc = 1;
        tick();
        total++;
        if ({busy, owner} !== 2'b10)
            $display("FAIL rr_tie_after_data: busy/owner=%b expected 10", {busy, owner});
        else passed++;
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        fx_i.cyc = 1; fx_i.stb = 1; fx_d.cyc = 1; fx_d.stb = 1;
        tick();
        total++;
        if ({fx_busy, fx_owner, fx_d.stall, fx_i.stall} !== 4'b1101)
            $display("FAIL fx_first_data: busy/owner/dstall/istall=%b expected 1101", {fx_busy, fx_owner, fx_d.stall, fx_i.stall});
        else passed++;
        tick();
        fx_d.stb = 0; fx_m.ack = 1; fx_m.rdata = 32'hCAFE_0001;
        #1;
        total++;
        if ({fx_d.ack, fx_i.ack, fx_d.rdata} !== {2'b10, 32'hCAFE_0001})
            $display("FAIL fx_ack_d: dack/iack=%b rdata=%h expected 10 cafe0001", {fx_d.ack, fx_i.ack}, fx_d.rdata);
        else passed++;
        tick();
        fx_m.ack = 0; fx_d.cyc = 0; fx_i.cyc = 0; fx_i.stb = 0;
        tick();
        total++;
        if (fx_busy !== 1'b0)
            $display("FAIL fx_idle: busy=%b expected 0", fx_busy);
        else passed++;
        fx_i.cyc = 1; fx_i.stb = 1; fx_d.cyc = 1; fx_d.stb = 1;
        tick();
        total++;
        if ({fx_busy, fx_owner} !== 2'b11)
            $display("FAIL fx_data_again: busy/owner=%b expected 11", {fx_busy, fx_owner});
        else passed++;
        tick();
        fx_d.stb = 0; fx_m.ack = 1;
        tick();
        fx_m.ack = 0; fx_d.cyc = 0;
        tick();
        total++;
        if ({fx_busy, fx_owner} !== 2'b10)
            $display("FAIL fx_handoff_i: busy/owner=%b expected 10", {fx_busy, fx_owner});
        else passed++;
    endtask

    task automatic test_saturation();
        apply_reset();
        ifi.cyc = 1; ifi.stb = 1; ifi.addr = 30'h100;
        tick();
        for (int k = 0; k < 8; k++) begin
            #1;
            total++;
            if ({mem.stb, ifi.stall} !== 2'b10)
                $display("FAIL sat_accept%0d: stb/stall=%b expected 10", k, {mem.stb, ifi.stall});
            else passed++;
            tick();
            ifi.addr = ifi.addr + 30'd1;
        end
        #1;
        total++;
        if ({mem.stb, ifi.stall, dut.u_cnt.count_o} !== 6'b01_1000)
            $display("FAIL sat_full: stb/stall/count=%b expected 011000", {mem.stb, ifi.stall, dut.u_cnt.count_o});
        else passed++;
        tick();
        mem.ack = 1;
        #1;
        total++;
        if ({mem.stb, ifi.stall, ifi.ack} !== 3'b011)
            $display("FAIL sat_ack_full: stb/stall/ack=%b expected 011", {mem.stb, ifi.stall, ifi.ack});
        else passed++;
        tick();
        mem.ack = 0;
        #1;
        total++;
        if ({mem.stb, ifi.stall} !== 2'b10)
            $display("FAIL sat_ninth: stb/stall=%b expected 10", {mem.stb, ifi.stall});
        else passed++;
        tick();
        ifi.stb = 0;
        #1;
        total++;
        if (dut.u_cnt.count_o !== 4'd8)
            $display("FAIL sat_refill: count=%0d expected 8", dut.u_cnt.count_o);
        else passed++;
        mem.ack = 1;
        tick();
        tick();
        tick();
        ifi.stb = 1;
        #1;
        total++;
        if (dut.u_cnt.count_o !== 4'd5)
            $display("FAIL cnt_before_both: count=%0d expected 5", dut.u_cnt.count_o);
        else passed++;
        tick();
        ifi.stb = 0;
        #1;
        total++;
        if (dut.u_cnt.count_o !== 4'd5)
            $display("FAIL cnt_accept_and_ack: count=%0d expected 5", dut.u_cnt.count_o);
        else passed++;
        for (int k = 0; k < 5; k++) tick();
        mem.ack = 0;
        #1;
        total++;
        if ({dut.u_cnt.count_o, spur} !== 5'b0000_0)
            $display("FAIL cnt_drained: count/spur=%b expected 00000", {dut.u_cnt.count_o, spur});
        else passed++;
        ifi.cyc = 0;
        tick();
        mem.ack = 1;
        #1;
        total++;
        if ({busy, ifi.ack, dai.ack, spur} !== 4'b0000)
            $display("FAIL spur_inject: busy/iack/dack/spur=%b expected 0000", {busy, ifi.ack, dai.ack, spur});
        else passed++;
        tick();
        mem.ack = 0;
        #1;
        total++;
        if ({spur, dut.u_cnt.count_o} !== 5'b1_0000)
            $display("FAIL spur_pulse: spur/count=%b expected 10000", {spur, dut.u_cnt.count_o});
        else passed++;
        tick();
        total++;
        if (spur !== 1'b0)
            $display("FAIL spur_one_cycle: spur=%b expected 0", spur);
        else passed++;
    endtask

    task automatic test_abort();
        apply_reset();
        ifi.cyc = 1; ifi.stb = 1;
        tick();
        tick();
        tick();
        tick();
        ifi.cyc = 0; ifi.stb = 0; dai.cyc = 1; dai.stb = 1;
        #1;
        total++;
        if (dut.u_cnt.count_o !== 4'd3)
            $display("FAIL abort_count: count=%0d expected 3", dut.u_cnt.count_o);
        else passed++;
        tick();
        for (int k = 0; k < 3; k++) begin
            mem.ack = 1;
            #1;
            total++;
            if ({mem.cyc, mem.stb, busy, ifi.stall, dai.stall, ifi.ack, dai.ack} !== 7'b1011100)
                $display("FAIL abort_drain%0d: cyc/stb/busy/istall/dstall/iack/dack=%b expected 1011100", k,
                         {mem.cyc, mem.stb, busy, ifi.stall, dai.stall, ifi.ack, dai.ack});
            else passed++;
            tick();
        end
        mem.ack = 0;
        #1;
        total++;
        if ({busy, mem.cyc} !== 2'b00)
            $display("FAIL abort_idle: busy/cyc=%b expected 00", {busy, mem.cyc});
        else passed++;
        tick();
        total++;
        if ({busy, owner, mem.cyc, mem.stb} !== 4'b1111)
            $display("FAIL abort_grant_d: busy/owner/cyc/stb=%b expected 1111", {busy, owner, mem.cyc, mem.stb});
        else passed++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        dai.cyc = 1; dai.stb = 1; dai.addr = 30'h55;
        tick();
        tick();
        tick();
        dai.stb = 0;
        #1;
        total++;
        if ({mem.cyc, dut.u_cnt.count_o} !== 5'b1_0010)
            $display("FAIL rstmid_before: cyc/count=%b expected 10010", {mem.cyc, dut.u_cnt.count_o});
        else passed++;
        #1;
        rst = 1;
        #1;
        total++;
        if ({mem.cyc, busy, dut.u_cnt.count_o} !== 6'b00_0000)
            $display("FAIL rstmid_async: cyc/busy/count=%b expected 000000", {mem.cyc, busy, dut.u_cnt.count_o});
        else passed++;
        dai.cyc = 0;
        tick();
        rst = 0;
        mem.ack = 1;
        #1;
        total++;
        if ({dai.ack, ifi.ack} !== 2'b00)
            $display("FAIL rstmid_late_ack: dack/iack=%b expected 00", {dai.ack, ifi.ack});
        else passed++;
        tick();
        total++;
        if ({spur, dai.ack} !== 2'b10)
            $display("FAIL rstmid_spur1: spur/dack=%b expected 10", {spur, dai.ack});
        else passed++;
        tick();
        mem.ack = 0;
        #1;
        total++;
        if (spur !== 1'b1)
            $display("FAIL rstmid_spur2: spur=%b expected 1", spur);
        else passed++;
        tick();
        total++;
        if ({spur, busy} !== 2'b00)
            $display("FAIL rstmid_quiet: spur/busy=%b expected 00", {spur, busy});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_fetch_burst();
        test_round_robin();
        test_fixed_priority();
        test_saturation();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
